// File: rtl/br_pkg.sv
// Shared types and constants for controllers that front the 8x32 register bank.
package br_pkg;

  localparam int BR_NUM_REGS = 8;
  localparam int BR_ADDR_W   = $clog2(BR_NUM_REGS);
  localparam int BR_DATA_W   = 32;
  localparam int BR_IDX_W    = 3;

  typedef struct packed {
    logic [BR_ADDR_W-1:0] n_reg;
    logic                 escrita;
    logic [BR_DATA_W-1:0] dado;
  } br_cmd_t;

  typedef struct packed {
    logic                valid;
    logic                is_read;
    logic [BR_IDX_W-1:0] idx;
  } br_tag_t;

endpackage

// File: rtl/arbitro_banco_registradores_if.sv
// Requester-side bundle of the register-bank arbiter: per-requester commands in, grants and read data out.
interface arbitro_banco_registradores_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_n_reg;
  logic [N_REQ-1:0]        req_escrita;
  logic [N_REQ*DATA_W-1:0] req_dado;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_dado;

  modport master (
    output req, req_n_reg, req_escrita, req_dado,
    input  gnt, rd_valid, rd_dado
  );

  modport slave (
    input  req, req_n_reg, req_escrita, req_dado,
    output gnt, rd_valid, rd_dado
  );

endinterface

// File: rtl/seletor_round_robin.sv
// Combinational round-robin pick: first eligible bit found searching upward from ptr, wrapping at N.
module seletor_round_robin #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elegivel,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  vencedor,
  output logic          algum
);

  always_comb begin
    int j;
    j        = 0;
    vencedor = '0;
    algum    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!algum && elegivel[j[IW-1:0]]) begin
        vencedor[j[IW-1:0]] = 1'b1;
        algum               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_banco_registradores.sv
// Round-robin arbiter sharing the single-port register bank among N_REQ requesters;
// reads return two edges after their grant, tagged with the issuing requester.
module arbitro_banco_registradores
  import br_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = BR_DATA_W,
  parameter int ADDR_W = BR_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  arbitro_banco_registradores_if.slave bus,
  output logic [ADDR_W-1:0]            br_n_reg,
  output logic                         br_escrita,
  output logic [DATA_W-1:0]            br_dado_escrito,
  input  logic [DATA_W-1:0]            br_dado_lido
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  elegivel;
  logic [N_REQ-1:0]  vencedor;
  logic              algum;
  logic [IW-1:0]     last_granted;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     idx_sel;
  br_cmd_t           cmd_sel;

  logic [N_REQ-1:0]  gnt_p0;
  br_cmd_t           cmd_p0;
  br_tag_t           tag_p0;
  br_tag_t           tag_p1;
  logic [N_REQ-1:0]  rd_valid_p2;
  logic [DATA_W-1:0] rd_dado_p2;

  // A requester granted last edge is still reacting to gnt, so it sits out one edge.
  assign elegivel = bus.req & ~gnt_p0;
  assign ptr      = (last_granted == IW'(N_REQ - 1)) ? '0 : last_granted + 1'b1;

  seletor_round_robin #(
    .N (N_REQ)
  ) u_seletor (
    .elegivel (elegivel),
    .ptr      (ptr),
    .vencedor (vencedor),
    .algum    (algum)
  );

  always_comb begin
    cmd_sel = '0;
    idx_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vencedor[i]) begin
        cmd_sel.n_reg   = bus.req_n_reg[i*ADDR_W +: ADDR_W];
        cmd_sel.escrita = bus.req_escrita[i];
        cmd_sel.dado    = bus.req_dado[i*DATA_W +: DATA_W];
        idx_sel         = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_p0       <= '0;
      cmd_p0       <= '0;
      tag_p0       <= '0;
      tag_p1       <= '0;
      rd_valid_p2  <= '0;
      rd_dado_p2   <= '0;
      last_granted <= IW'(N_REQ - 1);
    end else begin
      // p0: grant edge, command presented to the bank
      gnt_p0 <= vencedor;
      tag_p0 <= '0;
      if (algum) begin
        cmd_p0         <= cmd_sel;
        last_granted   <= idx_sel;
        tag_p0.valid   <= 1'b1;
        tag_p0.is_read <= ~cmd_sel.escrita;
        tag_p0.idx     <= BR_IDX_W'(idx_sel);
      end else begin
        cmd_p0.escrita <= 1'b0;
      end

      // p1: bank executes the command; its read data is registered inside the bank
      tag_p1 <= tag_p0;

      // p2: capture read data and route the valid pulse to its requester
      rd_valid_p2 <= '0;
      if (tag_p1.valid && tag_p1.is_read) begin
        rd_dado_p2 <= br_dado_lido;
        for (int i = 0; i < N_REQ; i++) begin
          if (tag_p1.idx == BR_IDX_W'(i)) rd_valid_p2[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt         = gnt_p0;
  assign bus.rd_valid    = rd_valid_p2;
  assign bus.rd_dado     = rd_dado_p2;
  assign br_n_reg        = cmd_p0.n_reg;
  assign br_escrita      = cmd_p0.escrita;
  assign br_dado_escrito = cmd_p0.dado;

endmodule

// File: tb/tb_arbitro_banco_registradores.sv
// Bench for the register-bank arbiter: a 2-requester and a 4-requester instance, each with its own bank model.
module tb_arbitro_banco_registradores;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } rd_exp_t;

  logic clk;
  logic rst;

  int checks;
  int errors;

  rd_exp_t exp_rd2[$];
  rd_exp_t exp_rd4[$];
  int      exp_g2[$];
  int      exp_g4[$];

  arbitro_banco_registradores_if #(.N_REQ(2), .DATA_W(32), .ADDR_W(3)) i2 ();
  arbitro_banco_registradores_if #(.N_REQ(4), .DATA_W(32), .ADDR_W(3)) i4 ();

  logic [2:0]  br2_n_reg, br4_n_reg;
  logic        br2_escrita, br4_escrita;
  logic [31:0] br2_dado_escrito, br4_dado_escrito;
  logic [31:0] lido2, lido4;
  logic [31:0] mem2 [8];
  logic [31:0] mem4 [8];

  arbitro_banco_registradores #(.N_REQ(2), .DATA_W(32), .ADDR_W(3)) dut2 (
    .clk             (clk),
    .rst             (rst),
    .bus             (i2),
    .br_n_reg        (br2_n_reg),
    .br_escrita      (br2_escrita),
    .br_dado_escrito (br2_dado_escrito),
    .br_dado_lido    (lido2)
  );

  arbitro_banco_registradores #(.N_REQ(4), .DATA_W(32), .ADDR_W(3)) dut4 (
    .clk             (clk),
    .rst             (rst),
    .bus             (i4),
    .br_n_reg        (br4_n_reg),
    .br_escrita      (br4_escrita),
    .br_dado_escrito (br4_dado_escrito),
    .br_dado_lido    (lido4)
  );

  // Bank models: one operation per edge, registered read data, no reset.
  always @(posedge clk) begin
    if (br2_escrita) mem2[br2_n_reg] <= br2_dado_escrito;
    else             lido2 <= mem2[br2_n_reg];
    if (br4_escrita) mem4[br4_n_reg] <= br4_dado_escrito;
    else             lido4 <= mem4[br4_n_reg];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic wait_g2(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i2.gnt[i] && n < 20);
    if (!i2.gnt[i]) begin
      checks++;
      errors++;
      $display("FAIL gnt2_timeout req%0d: got no grant in 20 cycles, expected a grant", i);
    end
  endtask

  task automatic wait_g4(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i4.gnt[i] && n < 20);
    if (!i4.gnt[i]) begin
      checks++;
      errors++;
      $display("FAIL gnt4_timeout req%0d: got no grant in 20 cycles, expected a grant", i);
    end
  endtask

  task automatic drive2(input int i, input bit wr, input logic [2:0] r, input logic [31:0] d);
    i2.req_escrita[i]       = wr;
    i2.req_n_reg[i*3 +: 3]  = r;
    i2.req_dado[i*32 +: 32] = d;
    i2.req[i]               = 1'b1;
    wait_g2(i);
  endtask

  task automatic drive4(input int i, input bit wr, input logic [2:0] r, input logic [31:0] d);
    i4.req_escrita[i]       = wr;
    i4.req_n_reg[i*3 +: 3]  = r;
    i4.req_dado[i*32 +: 32] = d;
    i4.req[i]               = 1'b1;
    wait_g4(i);
  endtask

  task automatic seq4(input int i);
    drive4(i, 1'b1, 3'(i), 32'(10 + i));
    drive4(i, 1'b0, 3'(i), 32'd0);
    i4.req[i] = 1'b0;
  endtask

  task automatic mon2();
    logic [1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (i2.gnt != '0) begin
        chk("gnt2_back_to_back", 32'(i2.gnt & prev), 0);
        if (exp_g2.size() == 0) chk("gnt2_unexpected", 32'(i2.gnt), 0);
        else chk("gnt2_order", 32'(i2.gnt), 32'(1 << exp_g2.pop_front()));
      end
      prev = i2.gnt;
      for (int i = 0; i < 2; i++) begin
        if (i2.rd_valid[i]) begin
          if (exp_rd2.size() == 0) chk("rd2_unexpected", 32'(i2.rd_valid), 0);
          else begin
            rd_exp_t e;
            e = exp_rd2.pop_front();
            chk("rd2_idx", 32'(i), 32'(e.idx));
            chk("rd2_dado", i2.rd_dado, e.data);
          end
        end
      end
    end
  endtask

  task automatic mon4();
    logic [3:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (i4.gnt != '0) begin
        chk("gnt4_back_to_back", 32'(i4.gnt & prev), 0);
        if (exp_g4.size() == 0) chk("gnt4_unexpected", 32'(i4.gnt), 0);
        else chk("gnt4_order", 32'(i4.gnt), 32'(1 << exp_g4.pop_front()));
      end
      prev = i4.gnt;
      for (int i = 0; i < 4; i++) begin
        if (i4.rd_valid[i]) begin
          if (exp_rd4.size() == 0) chk("rd4_unexpected", 32'(i4.rd_valid), 0);
          else begin
            rd_exp_t e;
            e = exp_rd4.pop_front();
            chk("rd4_idx", 32'(i), 32'(e.idx));
            chk("rd4_dado", i4.rd_dado, e.data);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    i2.req = '0; i2.req_n_reg = '0; i2.req_escrita = '0; i2.req_dado = '0;
    i4.req = '0; i4.req_n_reg = '0; i4.req_escrita = '0; i4.req_dado = '0;
    fork
      mon2();
      mon4();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(i2.gnt), 0);
    chk("rst_rd_valid", 32'(i2.rd_valid), 0);
    chk("rst_rd_dado", i2.rd_dado, 0);
    chk("rst_br_escrita", 32'(br2_escrita), 0);
    chk("rst_br_n_reg", 32'(br2_n_reg), 0);
    chk("rst_br_dado_escrito", br2_dado_escrito, 0);
    rst = 1'b0;

    // Single requester: write reg3=1001, then read it back.
    exp_g2.push_back(0); exp_g2.push_back(0);
    exp_rd2.push_back('{0, 32'd1001});
    drive2(0, 1'b1, 3'd3, 32'd1001);
    chk("t1_br_escrita", 32'(br2_escrita), 1);
    chk("t1_br_n_reg", 32'(br2_n_reg), 3);
    chk("t1_br_dado_escrito", br2_dado_escrito, 1001);
    i2.req_escrita[0] = 1'b0;
    @(negedge clk);
    chk("t1_bank_reg3", mem2[3], 1001);
    wait_g2(0);
    i2.req[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Two requesters holding req: grants alternate starting with 1 (0 granted last).
    exp_g2.push_back(1); exp_g2.push_back(0); exp_g2.push_back(1);
    exp_g2.push_back(0); exp_g2.push_back(1); exp_g2.push_back(0);
    exp_rd2.push_back('{1, 32'd999}); exp_rd2.push_back('{0, 32'd511});
    exp_rd2.push_back('{1, 32'd511}); exp_rd2.push_back('{0, 32'd999});
    fork
      begin
        drive2(1, 1'b1, 3'd0, 32'd999);
        drive2(1, 1'b0, 3'd0, 32'd0);
        drive2(1, 1'b0, 3'd7, 32'd0);
        i2.req[1] = 1'b0;
      end
      begin
        drive2(0, 1'b1, 3'd7, 32'd511);
        drive2(0, 1'b0, 3'd7, 32'd0);
        drive2(0, 1'b0, 3'd0, 32'd0);
        i2.req[0] = 1'b0;
      end
    join
    repeat (4) @(negedge clk);

    // Make requester 1 the last granted, then same-edge write reg1 (req 0) vs read reg1 (req 1).
    exp_g2.push_back(1); exp_g2.push_back(0); exp_g2.push_back(1);
    exp_rd2.push_back('{1, 32'd511}); exp_rd2.push_back('{1, 32'd100});
    drive2(1, 1'b0, 3'd7, 32'd0);
    i2.req[1] = 1'b0;
    @(negedge clk);
    fork
      drive2(0, 1'b1, 3'd1, 32'd100);
      drive2(1, 1'b0, 3'd1, 32'd0);
    join
    i2.req = '0;
    repeat (4) @(negedge clk);

    // Idle: bank only sees harmless reads; earlier data survives.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_br_escrita", 32'(br2_escrita), 0);
    end
    exp_g2.push_back(0);
    exp_rd2.push_back('{0, 32'd999});
    drive2(0, 1'b0, 3'd0, 32'd0);
    i2.req[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Reset right after a read grant (req 1) and a write grant (req 0, reg5=131).
    exp_g2.push_back(1); exp_g2.push_back(0);
    i2.req_escrita = 2'b01;
    i2.req_n_reg   = {3'd3, 3'd5};
    i2.req_dado    = {32'd0, 32'd131};
    i2.req         = 2'b11;
    wait_g2(1);
    wait_g2(0);
    rst    = 1'b1;
    i2.req = '0;
    @(negedge clk);
    chk("mrst_gnt", 32'(i2.gnt), 0);
    chk("mrst_rd_valid", 32'(i2.rd_valid), 0);
    chk("mrst_rd_dado", i2.rd_dado, 0);
    chk("mrst_br_escrita", 32'(br2_escrita), 0);
    chk("mrst_br_n_reg", 32'(br2_n_reg), 0);
    chk("mrst_br_dado_escrito", br2_dado_escrito, 0);
    chk("mrst_bank_reg5", mem2[5], 131);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_g2.push_back(0); exp_g2.push_back(1);
    exp_rd2.push_back('{0, 32'd131}); exp_rd2.push_back('{1, 32'd100});
    fork
      drive2(0, 1'b0, 3'd5, 32'd0);
      drive2(1, 1'b0, 3'd1, 32'd0);
    join
    i2.req = '0;
    repeat (4) @(negedge clk);

    // Four requesters all active: write reg i = 10+i, then read it back.
    for (int k = 0; k < 8; k++) exp_g4.push_back(k % 4);
    for (int k = 0; k < 4; k++) exp_rd4.push_back('{k, 32'(10 + k)});
    fork
      seq4(0);
      seq4(1);
      seq4(2);
      seq4(3);
    join
    repeat (4) @(negedge clk);

    chk("rd2_pending", 32'(exp_rd2.size()), 0);
    chk("gnt2_pending", 32'(exp_g2.size()), 0);
    chk("rd4_pending", 32'(exp_rd4.size()), 0);
    chk("gnt4_pending", 32'(exp_g4.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
